// File: rtl/multicycle_divider_pkg.sv
// Types and constants shared by the iterative M-extension divider and the execute stage.
package multicycle_divider_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIN  = 2'd2
    } div_state_e;

    // OP (0110011) funct3 encodings for the M-extension divide group
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        logic signed [XLEN-1:0] sv;
        sv = $signed(v);
        return neg ? $unsigned(-sv) : v;
    endfunction

endpackage

// File: rtl/multicycle_divider_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, subtract when it fits.
module multicycle_divider_div_step
    import multicycle_divider_pkg::*;
(
    input  logic [XLEN:0]   prem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   prem_o,
    output logic            q_bit_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN:0]   trial;

    always_comb begin
        shifted = {prem_i, bit_i};
        q_bit_o = (shifted >= {2'b00, divisor_i});
        trial   = shifted[XLEN:0] - {1'b0, divisor_i};
        prem_o  = q_bit_o ? trial : shifted[XLEN:0];
    end

endmodule

// File: rtl/multicycle_divider.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit: one quotient bit per cycle, calc/done handshake.
module multicycle_divider
    import multicycle_divider_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    input  logic        calc,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    div_state_e state_q, state_d;
    logic [32:0] prem_q, prem_d;
    logic [31:0] shreg_q, shreg_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        done_q, done_d;

    logic        dvd_neg;
    logic        dvs_neg;
    logic        overflow;
    logic [32:0] step_prem;
    logic        step_q;
    logic [31:0] q_raw;

    assign dvd_neg  = is_signed & dividend[31];
    assign dvs_neg  = is_signed & divisor[31];
    assign overflow = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
    assign q_raw    = {shreg_q[30:0], step_q};

    multicycle_divider_div_step u_step (
        .prem_i    (prem_q),
        .bit_i     (shreg_q[31]),
        .divisor_i (dvsr_q),
        .prem_o    (step_prem),
        .q_bit_o   (step_q)
    );

    always_comb begin
        state_d     = state_q;
        prem_d      = prem_q;
        shreg_d     = shreg_q;
        dvsr_d      = dvsr_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (calc) begin
                    q_neg_d = dvd_neg ^ dvs_neg;
                    r_neg_d = dvd_neg;
                    prem_d  = '0;
                    shreg_d = neg_if(dividend, dvd_neg);
                    dvsr_d  = neg_if(divisor, dvs_neg);
                    cnt_d   = '0;
                    if (divisor == 32'd0) begin
                        quotient_d  = 32'hFFFF_FFFF;
                        remainder_d = dividend;
                        done_d      = 1'b1;
                        state_d     = S_FIN;
                    end else if (overflow) begin
                        quotient_d  = 32'h8000_0000;
                        remainder_d = 32'd0;
                        done_d      = 1'b1;
                        state_d     = S_FIN;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                prem_d  = step_prem;
                shreg_d = q_raw;
                cnt_d   = cnt_q + 5'd1;
                // Results are registered on the edge into FIN so done and data line up.
                if (cnt_q == 5'd31) begin
                    quotient_d  = neg_if(q_raw, q_neg_q);
                    remainder_d = neg_if(step_prem[31:0], r_neg_q);
                    done_d      = 1'b1;
                    state_d     = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prem_q      <= '0;
            shreg_q     <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prem_q      <= prem_d;
            shreg_q     <= shreg_d;
            dvsr_q      <= dvsr_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign done      = done_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// Scoreboard bench for multicycle_divider: stimulus pushes expectations, a negedge monitor checks them.
module tb_multicycle_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        calc;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        done;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] held_q = '0;
    logic [31:0] held_r = '0;
    bit          clr_pend = 1'b0;

    multicycle_divider dut (
        .clk       (clk),
        .rst       (rst),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .calc      (calc),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RISC-V division rules with plain integer arithmetic.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit sgn, input int c0);
        exp_t   e;
        longint sa;
        longint sb_;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.cyc = c0 + 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
            e.cyc = c0 + 1;
        end else if (sgn) begin
            sa  = longint'($signed(a));
            sb_ = longint'($signed(b));
            e.q = 32'(sa / sb_);
            e.r = 32'(sa % sb_);
            e.cyc = c0 + 33;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.cyc = c0 + 33;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            clr_pend = 1'b1;
        end else begin
            if (clr_pend) begin
                held_q   = '0;
                held_r   = '0;
                clr_pend = 1'b0;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
                held_q = quotient;
                held_r = remainder;
            end else begin
                chk("hold_quotient", quotient, held_q);
                chk("hold_remainder", remainder, held_r);
            end
        end
    end

    // Called just after a rising edge; leaves calc low one edge later.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         input bit use_model, input logic [31:0] q, input logic [31:0] r,
                         input int lat, output int c0);
        exp_t e;
        #1;
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        calc      = 1'b1;
        c0        = cyc;
        if (use_model) begin
            e = model(a, b, sgn, c0);
        end else begin
            e.q = q;
            e.r = r;
            e.cyc = c0 + lat;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        calc      = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL done_timeout: %0d results still pending after %0d cycles", sb.size(), n);
            sb.delete();
        end
        @(posedge clk);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } dir_t;

    initial begin
        dir_t        dirs[$];
        int          c0;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;

        rst = 1'b1; calc = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(posedge clk);

        dirs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33});
        dirs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  33});
        dirs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          33});
        dirs.push_back('{32'h1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234,       1});
        dirs.push_back('{32'h1234,       32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234,       1});
        dirs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1});
        dirs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  33});
        dirs.push_back('{32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0,          33});
        foreach (dirs[i]) begin
            issue(dirs[i].a, dirs[i].b, dirs[i].s, 1'b0, dirs[i].q, dirs[i].r, dirs[i].lat, c0);
            wait_idle();
        end

        // A second calc in cycle 10 must be dropped.
        issue(32'd1000, 32'd9, 1'b0, 1'b0, 32'd111, 32'd1, 33, c0);
        repeat (9) @(posedge clk);
        #1;
        dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0; calc = 1'b1;
        @(posedge clk);
        #1;
        calc = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);

        // Reset in cycle 15 aborts the operation with no done.
        issue(32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 32'h5555_5555, 32'd0, 33, c0);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (40) @(posedge clk);
        issue(32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 32'd0, 33, c0);
        wait_idle();

        // Reset in the same cycle as calc wins.
        #1;
        rst = 1'b1; calc = 1'b1; dividend = 32'd77; divisor = 32'd0; is_signed = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; calc = 1'b0;
        repeat (40) @(posedge clk);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 17));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            issue(a, b, s, 1'b1, '0, '0, 0, c0);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_divider.md
# multicycle_divider

- Iterative 32-bit divider for the M-extension datapath, the inverse counterpart of the multicycle multiplier.
- Sits beside the multiplier in the execute stage and serves DIV, DIVU, REM and REMU through the same calc/done handshake.
- Implements radix-2 restoring division at one quotient bit per cycle.
- Divide-by-zero and signed overflow are short-circuited and return RISC-V-mandated results.

## Interface
Parameters: none (width fixed at 32).

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- dividend  input  32  numerator; sampled only on the accepting cycle
- divisor  input  32  denominator; sampled only on the accepting cycle
- is_signed  input  1  1 = two's-complement operands (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with the operands
- calc  input  1  start request; honoured only in IDLE
- quotient  output  32  registered quotient; valid when done=1, held until the next accepted calc
- remainder  output  32  registered remainder; valid when done=1, held until the next accepted calc
- done  output  1  single-cycle pulse marking valid results

## Operation
- States: IDLE, DIV, FIN.
- **IDLE**
  - If calc=0: stay in IDLE.
  - If calc=1: latch is_signed and both operands.
  - Compute magnitudes: |x| when is_signed=1, raw value otherwise.
  - Record the sign flags:
    - q_neg = sign(dividend) XOR sign(divisor)
    - r_neg = sign(dividend)
  - Load the 33-bit partial remainder with 0, the 32-bit shift register with |dividend|, and the iteration counter with 0.
  - Special cases go straight to FIN with preset results:
    - divisor==0: quotient=32'hFFFF_FFFF, remainder=raw dividend. This holds for both signednesses.
    - is_signed=1 and dividend==32'h8000_0000 and divisor==32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0.
  - Otherwise go to DIV.
- **DIV** (one iteration per cycle)
  - Form trial = {prem[31:0], shreg[31]} − {1'b0, |divisor|}.
  - If trial is non-negative: prem=trial, shift 1 into the quotient LSB.
  - Else: prem={prem[31:0], shreg[31]}, shift 0 in.
  - The counter increments each cycle; after iteration 31 (the 32nd) go to FIN.
- **FIN**
  - For the normal path, apply the sign fixes:
    - quotient = q_neg ? −q : q
    - remainder = r_neg ? −prem[31:0] : prem[31:0]
  - Register both results and assert done=1 for this cycle only.
  - Go to IDLE.
- calc arriving in DIV or FIN is ignored and not queued. The caller must hold calc low until done has been seen.
- Unsigned 32'h8000_0000 / 32'hFFFF_FFFF takes the normal path: quotient=0, remainder=32'h8000_0000.
- All arithmetic uses the 33-bit partial remainder, so no overflow occurs. Negating 32'h8000_0000 in the magnitude step yields 32'h8000_0000, which is correct as an unsigned magnitude.

## Timing
- **Reset**: state=IDLE; quotient=0, remainder=0, done=0; internal registers cleared.
- **Reset mid-operation**: aborts on the next edge with the reset values above; no done pulse follows.
- **Normal latency**: calc high in cycle 0 (IDLE); DIV occupies cycles 1–32; FIN with done=1 in cycle 33. Earliest re-accept is cycle 34.
- **Special-case latency**: calc in cycle 0; FIN with done=1 in cycle 1.
- **Output stability**: quotient and remainder change only on the edge that enters FIN. Operand inputs may change freely after cycle 0.
- **Reset precedence**: rst in the same cycle as calc wins; the request is dropped.

## Structure
- The shared rv32i_types package carries:
  - the divider state enum (IDLE/DIV/FIN)
  - the M-extension funct3 constants (DIV, DIVU, REM, REMU)
- Decoding funct3 into is_signed and selecting between quotient and remainder happens in the execute stage, not here.
- One sub-module, div_step: a combinational shift-compare-subtract taking prem, the incoming bit and the divisor, and returning the new prem and quotient bit.
- Estimated size is ~150–250 lines total.

## Test plan
- Unsigned 100/7, calc in cycle 0 → done only in cycle 33; quotient=14, remainder=2.
- Signed −7/2 (32'hFFFF_FFF9 / 2) → quotient=32'hFFFF_FFFD, remainder=32'hFFFF_FFFF. Signed 7/−2 → quotient=32'hFFFF_FFFD, remainder=1.
- Divide by zero: 32'h1234/0 with is_signed 0, then again with is_signed 1 → done in cycle 1; quotient=32'hFFFF_FFFF, remainder=32'h1234.
- Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF → done in cycle 1; quotient=32'h8000_0000, remainder=0. The same operands unsigned → done in cycle 33; quotient=0, remainder=32'h8000_0000.
- calc pulsed again in cycle 10 with different operands → ignored; the original result appears in cycle 33 and exactly one done pulse is seen.
- rst asserted in cycle 15 of a 32'hFFFF_FFFF/3 operation → cycle 16 shows IDLE with all outputs 0 and no done. A fresh 9/3 issued afterwards returns quotient=3, remainder=0.
